// File: rtl/mem_ctrl.sv
// Single-port word memory with byte-enable writes and registered reads.
// After every reset the whole array is cleared to zero before requests are accepted.
module mem_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  localparam int BE_WIDTH  = WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  in_range;
  logic                  accept;

  // One extra bit so DEPTH itself is representable when it equals 2**ADDR_WIDTH.
  assign in_range    = ({1'b0, addr_i} < DEPTH_EXT);
  assign accept      = req_i && (state == RUN);
  assign ready_o     = (state == RUN);
  assign init_done_o = (state == RUN);

  // Memory is never touched while reset is held; the clear runs only after release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (accept && we_i && in_range) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be_i[b]) begin
            mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= INIT;
      cnt      <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == LAST_ADDR) begin
            state <= RUN;
          end
          cnt <= cnt + 1'b1;
        end
        default: begin
          if (accept) begin
            err_o <= !in_range;
            // Out-of-range reads still complete, returning zero alongside the error.
            if (!we_i) begin
              rvalid_o <= 1'b1;
              if (in_range) begin
                rdata_o <= mem[addr_i];
              end else begin
                rdata_o <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
